// File: rtl/branch_resolver.sv
// branch_resolver: in-order queue of fetched branch predictions, resolved against execute outcomes
// to drive predictor/BTB updates, front-end redirects and saturating perf counters.
module branch_resolver #(
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_enq_valid,
    input  logic [DATA_WIDTH-1:0] i_enq_pc,
    input  logic                  i_enq_hit,
    input  logic                  i_enq_pred,
    input  logic [DATA_WIDTH-1:0] i_enq_target,
    output logic                  o_enq_ready,
    input  logic                  i_res_valid,
    input  logic                  i_res_taken,
    input  logic [DATA_WIDTH-1:0] i_res_target,
    output logic                  o_update_predictor,
    output logic                  o_update_btb,
    output logic                  o_actually_taken,
    output logic [DATA_WIDTH-1:0] o_resolved_pc,
    output logic [DATA_WIDTH-1:0] o_resolved_pc_target,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    output logic [CNT_WIDTH-1:0]  o_branch_count,
    output logic [CNT_WIDTH-1:0]  o_mispredict_count,
    output logic                  o_underflow_err
);
    localparam int PW = $clog2(QUEUE_DEPTH);

    logic [DATA_WIDTH-1:0] r_pc  [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] r_tgt [QUEUE_DEPTH];
    logic                  r_hit [QUEUE_DEPTH];
    logic                  r_pred[QUEUE_DEPTH];
    logic [PW-1:0]         r_head, r_tail;
    logic [PW:0]           r_count;
    logic                  r_upd, r_btb, r_taken, r_rv, r_uf;
    logic [DATA_WIDTH-1:0] r_rpc, r_rtgt, r_rdpc;
    logic [CNT_WIDTH-1:0]  r_bc, r_mc;

    logic                  w_enq, w_res, w_mis;
    logic [DATA_WIDTH-1:0] w_pc4, w_pred_next, w_act_next;

    assign o_enq_ready = r_count < (PW+1)'(QUEUE_DEPTH);
    assign w_enq       = i_enq_valid && o_enq_ready;
    assign w_res       = i_res_valid && r_count != '0;
    assign w_pc4       = r_pc[r_head] + DATA_WIDTH'(4);
    assign w_pred_next = (r_hit[r_head] && r_pred[r_head]) ? r_tgt[r_head] : w_pc4;
    assign w_act_next  = i_res_taken ? i_res_target : w_pc4;
    assign w_mis       = w_res && (w_pred_next != w_act_next);

    // Wrong-path enqueues during a mispredict never touch the payload.
    always_ff @(posedge clk) begin
        if (w_enq && !w_mis) begin
            r_pc[r_tail]   <= i_enq_pc;
            r_tgt[r_tail]  <= i_enq_target;
            r_hit[r_tail]  <= i_enq_hit;
            r_pred[r_tail] <= i_enq_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_upd   <= 1'b0;
            r_btb   <= 1'b0;
            r_taken <= 1'b0;
            r_rv    <= 1'b0;
            r_uf    <= 1'b0;
            r_rpc   <= '0;
            r_rtgt  <= '0;
            r_rdpc  <= '0;
            r_bc    <= '0;
            r_mc    <= '0;
        end else begin
            r_upd <= w_res;
            r_btb <= w_res && i_res_taken;
            r_rv  <= w_mis;
            if (i_res_valid && r_count == '0)
                r_uf <= 1'b1;
            if (w_res) begin
                r_taken <= i_res_taken;
                r_rpc   <= r_pc[r_head];
                r_rtgt  <= i_res_target;
                r_head  <= r_head + PW'(1);
                if (r_bc != '1)
                    r_bc <= r_bc + CNT_WIDTH'(1);
            end
            if (w_mis) begin
                r_rdpc  <= w_act_next;
                r_count <= '0;
                r_tail  <= r_head + PW'(1);
                if (r_mc != '1)
                    r_mc <= r_mc + CNT_WIDTH'(1);
            end else begin
                if (w_enq)
                    r_tail <= r_tail + PW'(1);
                r_count <= r_count + (PW+1)'(w_enq) - (PW+1)'(w_res);
            end
        end
    end

    assign o_update_predictor   = r_upd;
    assign o_update_btb         = r_btb;
    assign o_actually_taken     = r_taken;
    assign o_resolved_pc        = r_rpc;
    assign o_resolved_pc_target = r_rtgt;
    assign o_redirect_valid     = r_rv;
    assign o_redirect_pc        = r_rdpc;
    assign o_branch_count       = r_bc;
    assign o_mispredict_count   = r_mc;
    assign o_underflow_err      = r_uf;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed steps against a reference queue model; expected
// per-cycle outputs are pushed to a scoreboard and compared after each edge.
module tb_branch_resolver;
    logic        clk = 1'b0, rst = 1'b0;
    logic        enq_valid = 1'b0, enq_hit = 1'b0, enq_pred = 1'b0, enq_ready;
    logic [31:0] enq_pc = '0, enq_target = '0, res_target = '0;
    logic        res_valid = 1'b0, res_taken = 1'b0;
    logic        update_predictor, update_btb, actually_taken, redirect_valid, underflow_err;
    logic [31:0] resolved_pc, resolved_pc_target, redirect_pc;
    logic [3:0]  branch_count, mispredict_count;

    branch_resolver #(.DATA_WIDTH(32), .QUEUE_DEPTH(4), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .i_enq_valid(enq_valid), .i_enq_pc(enq_pc), .i_enq_hit(enq_hit),
        .i_enq_pred(enq_pred), .i_enq_target(enq_target), .o_enq_ready(enq_ready),
        .i_res_valid(res_valid), .i_res_taken(res_taken), .i_res_target(res_target),
        .o_update_predictor(update_predictor), .o_update_btb(update_btb),
        .o_actually_taken(actually_taken), .o_resolved_pc(resolved_pc),
        .o_resolved_pc_target(resolved_pc_target), .o_redirect_valid(redirect_valid),
        .o_redirect_pc(redirect_pc), .o_branch_count(branch_count),
        .o_mispredict_count(mispredict_count), .o_underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        hit, pred;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic        upd, btb, taken, rv, uf, ready;
        logic [31:0] rpc, rtgt, rdpc;
        logic [3:0]  bc, mc;
    } exp_t;

    ent_t        m_q[$];
    exp_t        sb[$];
    exp_t        m;
    int          n_vec = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic ev, input logic [31:0] pc, input logic h,
                        input logic p, input logic [31:0] t, input logic rv, input logic tk,
                        input logic [31:0] rt);
        exp_t  e;
        ent_t  he;
        logic  ready_now, mis;
        logic [31:0] pn, an;
        rst = r; enq_valid = ev; enq_pc = pc; enq_hit = h; enq_pred = p; enq_target = t;
        res_valid = rv; res_taken = tk; res_target = rt;
        ready_now = m_q.size() < 4;
        mis = 1'b0;
        m.upd = 1'b0; m.btb = 1'b0; m.rv = 1'b0;
        if (r) begin
            m_q.delete();
            m = '{default: '0};
        end else begin
            if (rv && m_q.size() == 0) m.uf = 1'b1;
            if (rv && m_q.size() != 0) begin
                he = m_q.pop_front();
                pn = (he.hit && he.pred) ? he.tgt : he.pc + 32'd4;
                an = tk ? rt : he.pc + 32'd4;
                mis = pn != an;
                m.upd = 1'b1; m.btb = tk; m.taken = tk; m.rpc = he.pc; m.rtgt = rt;
                if (m.bc != 4'hF) m.bc++;
                if (mis) begin
                    m.rv = 1'b1; m.rdpc = an;
                    if (m.mc != 4'hF) m.mc++;
                    m_q.delete();
                end
            end
            if (ev && ready_now && !mis) m_q.push_back('{pc, h, p, t});
        end
        m.ready = m_q.size() < 4;
        sb.push_back(m);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("update_predictor", 32'(update_predictor), 32'(e.upd));
        chk("update_btb", 32'(update_btb), 32'(e.btb));
        chk("actually_taken", 32'(actually_taken), 32'(e.taken));
        chk("resolved_pc", resolved_pc, e.rpc);
        chk("resolved_pc_target", resolved_pc_target, e.rtgt);
        chk("redirect_valid", 32'(redirect_valid), 32'(e.rv));
        chk("redirect_pc", redirect_pc, e.rdpc);
        chk("branch_count", 32'(branch_count), 32'(e.bc));
        chk("mispredict_count", 32'(mispredict_count), 32'(e.mc));
        chk("underflow_err", 32'(underflow_err), 32'(e.uf));
        chk("enq_ready", 32'(enq_ready), 32'(e.ready));
    endtask

    task automatic enq(input logic [31:0] pc, input logic h, input logic p, input logic [31:0] t);
        step(1'b0, 1'b1, pc, h, p, t, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic res(input logic tk, input logic [31:0] rt);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, tk, rt);
    endtask

    initial begin
        m = '{default: '0};
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
        // correct not-taken
        enq(32'h100, 0, 0, 0);
        res(1'b0, 32'h0);
        // taken miss on BTB miss
        enq(32'h200, 0, 0, 0);
        res(1'b1, 32'h400);
        // wrong target: squash younger entries and drop the same-cycle enqueue
        enq(32'h300, 1, 1, 32'h500);
        enq(32'h304, 0, 0, 0);
        enq(32'h308, 0, 0, 0);
        step(1'b0, 1'b1, 32'h30C, 0, 0, 0, 1'b1, 1'b1, 32'h600);
        res(1'b0, 32'h0);
        // fill, overfill, then resolve while enqueuing across the pointer wrap
        for (int i = 0; i < 4; i++) enq(32'h1000 + 32'(i * 4), 0, 0, 0);
        enq(32'h1FF0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, 32'h2000 + 32'(i * 8), 1'b1, 1'b1, 32'h3000 + 32'(i * 8),
                 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) res(1'b1, 32'h3000 + 32'(i * 8) + 32'd8);
        res(1'b0, 32'h0);
        // counter saturation
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            enq(32'h4000 + 32'(i * 4), 0, 0, 0);
            res(1'b1, 32'h8000 + 32'(i * 4));
        end
        // reset overrides a concurrent resolve
        for (int i = 0; i < 3; i++) enq(32'h5000 + 32'(i * 4), 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0, 1'b1, 1'b1, 32'h9000);
        step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
        res(1'b0, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Fetch-to-execute companion of the branch predictor/BTB block. Records each fetched control-flow instruction's prediction (pc, BTB hit, predicted direction, predicted target) in an in-order queue. When execute resolves the oldest branch, it compares the actual outcome with the recorded prediction and drives the predictor/BTB update interface. On a misprediction it issues a front-end redirect and squashes all younger queue entries. It also keeps saturating branch and misprediction counters.

## Interface
- DATA_WIDTH, 32, pc/target width
- QUEUE_DEPTH, 4, in-flight branch entries; power of two, ≥2
- CNT_WIDTH, 16, performance counter width
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- enq_valid  in  1  fetch pushes a control-flow instruction
- enq_pc  in  DATA_WIDTH  fetch pc
- enq_hit  in  1  BTB hit at fetch
- enq_pred  in  1  predicted taken at fetch
- enq_target  in  DATA_WIDTH  BTB target at fetch
- enq_ready  out  1  queue not full, combinational from occupancy
- res_valid  in  1  execute resolves the oldest queued branch
- res_taken  in  1  actual direction
- res_target  in  DATA_WIDTH  actual taken target
- update_predictor  out  1  one-cycle pulse per resolution
- update_btb  out  1  one-cycle pulse when resolved taken
- actually_taken  out  1  resolved direction
- resolved_pc  out  DATA_WIDTH  pc of the resolved branch
- resolved_pc_target  out  DATA_WIDTH  res_target of the resolved branch
- redirect_valid  out  1  one-cycle pulse on misprediction
- redirect_pc  out  DATA_WIDTH  correct next pc
- branch_count  out  CNT_WIDTH  resolved branches, saturating
- mispredict_count  out  CNT_WIDTH  mispredictions, saturating
- underflow_err  out  1  sticky; res_valid arrived with the queue empty

## Operation
- Circular queue with head/tail pointers of log2(QUEUE_DEPTH) bits and an occupancy count of log2(QUEUE_DEPTH)+1 bits. Pointers wrap modulo QUEUE_DEPTH.
- Enqueue: fires when enq_valid && enq_ready. Writes {pc, hit, pred, target} at the tail.
- Resolve: fires when res_valid && count != 0. Pops the head entry.
  - predicted_next = (hit && pred) ? target : pc+4.
  - actual_next = res_taken ? res_target : pc+4.
  - pc+4 is computed modulo 2^DATA_WIDTH.
  - mispredict = predicted_next != actual_next.
- Resolution outputs:
  - update_predictor = 1 and actually_taken = res_taken.
  - resolved_pc = head pc and resolved_pc_target = res_target.
  - update_btb = res_taken.
- Misprediction: redirect_valid = 1 and redirect_pc = actual_next. The queue is cleared: count ← 0 and tail ← head+1, leaving head == tail. Any enqueue in that same cycle is dropped as wrong-path.
- Counters: branch_count increments on every resolve; mispredict_count increments on every mispredict. Both saturate at 2^CNT_WIDTH−1.
- Underflow: res_valid with count == 0 sets underflow_err, changes no other state and produces no update pulse. underflow_err is cleared only by rst.
- Simultaneous enqueue and non-mispredicting resolve: both happen and count is unchanged.
- enq_ready = count < QUEUE_DEPTH. It ignores a same-cycle dequeue, so a full queue with a concurrent resolve still refuses the enqueue.
- Reset clears pointers, count, counters, underflow_err and all output pulses. Queue payload storage is not reset.

## Timing
- Queue state, counters and all outputs except enq_ready are registered.
- Resolve-to-output latency is 1 cycle: the update_*, redirect_* and resolved_* outputs are valid in the cycle after res_valid.
- Pulses last exactly one cycle unless another resolve follows back-to-back. Back-to-back resolves give back-to-back pulses.
- Enqueue-to-resolvable latency is 1 cycle; there is no bypass. res_valid in the same cycle as the first enqueue into an empty queue is an underflow.
- Reset values: update_predictor, update_btb, actually_taken, redirect_valid and underflow_err = 0. resolved_pc, resolved_pc_target and redirect_pc = 0. Counters = 0. enq_ready = 1 in the first cycle after reset.
- rst asserted mid-operation takes effect at the next edge and overrides any enqueue or resolve in that cycle.

## Test plan
- Correct not-taken: enq pc=0x100, hit=0, pred=0; resolve taken=0.
  - Next cycle: update_predictor=1, update_btb=0, resolved_pc=0x100, redirect_valid=0.
  - branch_count=1, mispredict_count=0.
- Taken miss: enq pc=0x200, hit=0; resolve taken=1, target=0x400.
  - update_btb=1, resolved_pc_target=0x400.
  - redirect_valid=1, redirect_pc=0x400, mispredict_count=1.
- Wrong target and squash: enq pc=0x300 (hit=1, pred=1, target=0x500), then 0x304 and 0x308. Resolve taken=1, target=0x600.
  - redirect_pc=0x600.
  - Count becomes 0 and enq_ready=1. A following res_valid sets underflow_err.
- Full and wrap: enqueue 4 entries.
  - enq_ready=0, and a 5th enq is ignored.
  - Resolve 4 correctly predicted entries while enqueuing 4 more to cross the pointer wrap. Resolved_pc order must match enqueue order.
- Saturation: with CNT_WIDTH=4, resolve 20 mispredicted branches. Both counters hold at 15.
- Reset mid-stream: 3 entries queued, rst asserted together with res_valid.
  - No update pulse.
  - count=0, outputs at reset values, enq_ready=1.
